fast_band_sched: RTL and testbench

- Frame-level scheduler in front of the 8-FIFO single-window partial buffer of the FAST pipeline.
- Issues one MM2S DMA command per 8-row band of a pre-interleaved frame buffer.
- Limits outstanding bands using completion pulses from the patch/score side, and monitors the AXI-stream beats entering the buffer for framing errors.
- Reports busy/done/error to the PS register block.

---
 rtl/fast_band_sched.sv | 145 ++++++++++++++
 tb/tb_fast_band_sched.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fast_band_sched.sv
// fast_band_sched: issues one MM2S command per 8-row band, limits outstanding bands, and watches stream framing.
// Optional macro FAST_SCHED_PERF_EN adds perf_cycles / perf_stall counters.
module fast_band_sched #(
  parameter int COL_NUM         = 640,
  parameter int ROW_NUM         = 480,
  parameter int ADDR_WIDTH      = 32,
  parameter int LEN_WIDTH       = 23,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] frame_base,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  mon_tvalid,
  input  logic                  mon_tready,
  input  logic                  mon_tlast,
  input  logic                  band_done,
  output logic                  swpb_flush,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_framing
`ifdef FAST_SCHED_PERF_EN
  ,
  output logic [31:0]           perf_cycles,
  output logic [31:0]           perf_stall
`endif
);

  localparam int NUM_BANDS  = (ROW_NUM - 8) / 2 + 1;
  localparam int BAND_WORDS = COL_NUM * 2;
  localparam int BAND_BYTES = COL_NUM * 8;
  localparam int BW = $clog2(NUM_BANDS + 1);
  localparam int WW = $clog2(BAND_WORDS);
  localparam int OW = 3;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN, S_DONE, S_ABORT} state_t;

  state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BW-1:0]   issue_q, done_q;
  logic [OW-1:0]   outst_q, outst_d;
  logic [WW-1:0]   beat_q;

  logic start_acc, abort_acc, hs, bd_ok, bd_bad, mon_ev, last_beat, beat_err;

  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign start_acc = start && (state_q == S_IDLE);
  assign abort_acc = abort && (state_q != S_IDLE);
  assign hs        = cmd_valid && cmd_ready && !abort_acc;
  assign bd_ok     = band_done && busy && !abort_acc && (outst_q != '0);
  assign bd_bad    = band_done && busy && !abort_acc && (outst_q == '0);
  assign mon_ev    = mon_tvalid && mon_tready && busy && !abort_acc;
  assign last_beat = (beat_q == WW'(BAND_WORDS - 1));
  assign beat_err  = mon_ev && (mon_tlast != last_beat);
  assign cmd_addr  = addr_q;
  assign cmd_len   = LEN_WIDTH'(BAND_BYTES);

  // A completion landing in the same cycle as a handshake cancels out.
  always_comb begin
    outst_d = outst_q;
    if (hs && !bd_ok)      outst_d = outst_q + OW'(1);
    else if (!hs && bd_ok) outst_d = outst_q - OW'(1);
  end

  always_comb begin
    state_d    = state_q;
    cmd_valid  = 1'b0;
    frame_done = 1'b0;
    swpb_flush = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ISSUE;
      S_ISSUE: begin
        cmd_valid = 1'b1;
        if (hs) begin
          if (issue_q + BW'(1) == BW'(NUM_BANDS))    state_d = S_DRAIN;
          else if (outst_d == OW'(MAX_OUTSTANDING)) state_d = S_WAIT;
        end
      end
      S_WAIT:  if (outst_q < OW'(MAX_OUTSTANDING)) state_d = S_ISSUE;
      S_DRAIN: if (done_q == BW'(NUM_BANDS)) state_d = S_DONE;
      S_DONE:  begin
        frame_done = 1'b1;
        state_d    = S_IDLE;
      end
      S_ABORT: begin
        swpb_flush = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort_acc) state_d = S_ABORT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      issue_q     <= '0;
      done_q      <= '0;
      outst_q     <= '0;
      beat_q      <= '0;
      err_framing <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        addr_q      <= frame_base;
        issue_q     <= '0;
        done_q      <= '0;
        outst_q     <= '0;
        beat_q      <= '0;
        err_framing <= 1'b0;
      end else begin
        outst_q <= outst_d;
        if (hs) begin
          addr_q  <= addr_q + ADDR_WIDTH'(BAND_BYTES);
          issue_q <= issue_q + BW'(1);
        end
        if (bd_ok)  done_q <= done_q + BW'(1);
        if (mon_ev) beat_q <= last_beat ? '0 : beat_q + WW'(1);
        if (bd_bad || beat_err) err_framing <= 1'b1;
      end
    end
  end

`ifdef FAST_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (start_acc) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
      if (state_q == S_WAIT && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fast_band_sched.sv
// Directed bench for fast_band_sched with a transaction-level scoreboard (addresses, credits, frame end).
`timescale 1ns/1ps
module tb_fast_band_sched;
  localparam int COLS = 640, ROWS = 480, MAXO = 2;
  localparam int NB = (ROWS - 8) / 2 + 1;
  localparam int BWORDS = COLS * 2;
  localparam int BB = COLS * 8;

  logic clk = 0, rst_n = 0, start = 0, abort = 0, cmd_ready = 0;
  logic mon_tvalid = 0, mon_tready = 0, mon_tlast = 0, bd_auto = 0, bd_man = 0, band_done;
  logic [31:0] frame_base = 0, cmd_addr;
  logic [22:0] cmd_len;
  logic cmd_valid, swpb_flush, busy, frame_done, err_framing;

  assign band_done = bd_auto | bd_man;
  always #5 clk = ~clk;

  fast_band_sched #(.COL_NUM(COLS), .ROW_NUM(ROWS), .ADDR_WIDTH(32), .LEN_WIDTH(23),
                    .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .frame_base(frame_base),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
    .band_done(band_done), .swpb_flush(swpb_flush), .busy(busy), .frame_done(frame_done),
    .err_framing(err_framing));

  int nchk = 0, nerr = 0, cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Frame-level model: band k of a frame must go out at base + k*BB, never more than
  // MAXO bands beyond the accepted completions, and the frame ends after NB of each.
  logic m_act = 0, auto_en = 0, p_stall = 0;
  logic [31:0] m_base = 0, last_addr = 0, p_addr = 0;
  int m_hs = 0, m_dn = 0, n_fd = 0, last_bd = 0, fd_cyc = 0;
  int due[$];

  always @(negedge clk) begin
    int out0;
    if (rst_n) begin
      if (p_stall) begin
        chk("hold_valid", cmd_valid, 1);
        chk("hold_addr", cmd_addr, p_addr);
        chk("hold_len", cmd_len, BB);
      end
      p_stall = m_act && cmd_valid && !cmd_ready && !abort;
      p_addr  = cmd_addr;
      if (!m_act) begin
        chk("idle_valid", cmd_valid, 0);
        chk("idle_frame_done", frame_done, 0);
      end
      if (m_act && abort) m_act = 0;
      else if (m_act) begin
        out0 = m_hs - m_dn;
        if (band_done) begin
          if (out0 > 0) m_dn++;
          last_bd = cyc;
        end
        if (cmd_valid && cmd_ready) begin
          chk("cmd_addr", cmd_addr, m_base + 32'(m_hs * BB));
          chk("cmd_len", cmd_len, BB);
          chk("credit_limit", out0 < MAXO, 1);
          chk("band_range", m_hs < NB, 1);
          last_addr = cmd_addr;
          m_hs++;
          if (auto_en) due.push_back(cyc + 20);
        end
        if (frame_done) begin
          chk("fd_bands_issued", m_hs, NB);
          chk("fd_bands_done", m_dn, NB);
          n_fd++;
          fd_cyc = cyc;
          m_act = 0;
        end
      end else if (start) begin
        m_act = 1; m_base = frame_base; m_hs = 0; m_dn = 0;
      end
    end
  end

  // Completion responder: band_done 20 cycles after each handshake.
  initial forever begin
    @(posedge clk); #1;
    bd_auto = (due.size() > 0 && due[0] <= cyc);
    if (bd_auto) void'(due.pop_front());
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start(input logic [31:0] b);
    frame_base = b; start = 1; tick(); start = 0;
  endtask

  task automatic pulse_bd();
    bd_man = 1; tick(); bd_man = 0;
  endtask

  task automatic wait_fd(input int target, input int lim);
    int k = 0;
    while (n_fd < target && k < lim) begin tick(); k++; end
    chk("frame_done_timeout", n_fd >= target, 1);
  endtask

  task automatic stream_band(input int bad);
    mon_tvalid = 1; mon_tready = 1;
    for (int i = 0; i < BWORDS; i++) begin
      mon_tlast = (i == BWORDS - 1) || (i == bad);
      tick();
    end
    mon_tvalid = 0; mon_tready = 0; mon_tlast = 0;
  endtask

  initial begin
    int k;
    tick(2);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_addr", cmd_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_flush", swpb_flush, 0);
    chk("rst_err", err_framing, 0);
    rst_n = 1; tick(2);

    // full frame, ready always high
    auto_en = 1; cmd_ready = 1;
    pulse_start(32'h1000_0000);
    chk("t1_first_valid", cmd_valid, 1);
    chk("t1_first_addr", cmd_addr, 32'h1000_0000);
    chk("t1_busy", busy, 1);
    wait_fd(1, 20000);
    tick(3);
    chk("t1_band_count", m_hs, NB);
    chk("t1_last_addr", last_addr, 32'h1012_7000);
    chk("t1_frame_dones", n_fd, 1);
    chk("t1_err", err_framing, 0);
    chk("t1_busy_end", busy, 0);
    chk("t1_done_latency", fd_cyc - last_bd, 2);

    // completions withheld, framing monitor, ready stall
    auto_en = 0;
    pulse_start(32'h2000_0000);
    tick(30);
    chk("t2_hs_capped", m_hs, 2);
    chk("t2_valid_low", cmd_valid, 0);
    for (int b = 0; b < 3; b++) stream_band(-1);
    chk("t2_stream_ok", err_framing, 0);
    stream_band(1000);
    chk("t2_stream_bad", err_framing, 1);
    pulse_bd(); tick(10);
    chk("t2_one_more", m_hs, 3);
    chk("t2_valid_low2", cmd_valid, 0);
    cmd_ready = 0;
    pulse_bd();
    k = 0;
    while (!cmd_valid && k < 10) begin tick(); k++; end
    chk("t2_stall_valid", cmd_valid, 1);
    repeat (5) begin
      chk("t2_stall_addr", cmd_addr, 32'h2000_0000 + 32'(3 * BB));
      tick();
    end
    chk("t2_stall_no_hs", m_hs, 3);
    cmd_ready = 1; tick();
    chk("t2_stall_one_hs", m_hs, 4);
    auto_en = 1;
    pulse_bd(); tick(); pulse_bd();
    wait_fd(2, 20000);
    tick(2);
    chk("t2_frame_dones", n_fd, 2);
    chk("t2_err_sticky", err_framing, 1);

    // abort during credit wait
    auto_en = 0;
    pulse_start(32'h3000_0000);
    chk("t3_err_cleared", err_framing, 0);
    tick(10);
    chk("t3_hs", m_hs, 2);
    abort = 1; tick(); abort = 0;
    chk("t3_flush", swpb_flush, 1);
    chk("t3_abort_valid", cmd_valid, 0);
    chk("t3_busy_abort", busy, 1);
    tick();
    chk("t3_flush_end", swpb_flush, 0);
    chk("t3_busy_low", busy, 0);
    tick(20);
    chk("t3_no_frame_done", n_fd, 2);

    // restart at new base; stray completion; completion coinciding with handshake
    cmd_ready = 0;
    pulse_start(32'h4000_0000);
    chk("t4_valid", cmd_valid, 1);
    chk("t4_addr", cmd_addr, 32'h4000_0000);
    chk("t4_err_pre", err_framing, 0);
    pulse_bd();
    chk("t4_stray_bd_err", err_framing, 1);
    cmd_ready = 1; tick();
    pulse_bd(); tick(10);
    chk("t4_same_cycle_hs", m_hs, 3);
    chk("t4_first_band", last_addr, 32'h4000_0000 + 32'(2 * BB));
    abort = 1; tick(); abort = 0; tick(3);
    chk("t4_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #500000;
    nerr++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
